// File: rtl/gradient_pkg.sv
// Shared types for the Prewitt gradient path: pixel/window types and the window FSM states.
// Optional status output of kernel_window_5x5 is enabled with KERNEL_WINDOW_STATUS_EN.
package gradient_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int KERNEL_SIZE_DEF = 5;

   typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

   // Packed so it can cross module ports directly; indexed [row][col], [0][0] is oldest.
   typedef pixel_t [0:KERNEL_SIZE_DEF-1][0:KERNEL_SIZE_DEF-1] window_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ACTIVE,
      DONE
   } win_state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// One image line of storage: combinational read and synchronous write at a shared address.
// Enabling KERNEL_WINDOW_STATUS_EN has no effect on this module.
module line_buffer_ram
   import gradient_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 640,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Read returns the old word, so a chained write in the same cycle sees pre-write data.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/kernel_window_5x5.sv
// Raster stream to sliding KERNEL_SIZE x KERNEL_SIZE window; emits only fully-populated windows.
// Define KERNEL_WINDOW_STATUS_EN to add the o_frame_error status pulse.
module kernel_window_5x5
   import gradient_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480
) (
   input  logic                  i_clk,
   input  logic                  i_aresetn,
   input  logic [DATA_WIDTH-1:0] i_pixel,
   input  logic                  i_data_valid,
   input  logic                  i_start_of_frame,
   output logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel_buffer,
   output logic                  o_data_valid,
   output logic                  o_start_of_frame
`ifdef KERNEL_WINDOW_STATUS_EN
   ,
   output logic                  o_frame_error
`endif
);

   localparam int K  = KERNEL_SIZE;
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [RW-1:0] ROW_FILL  = RW'(K - 2);

   win_state_e state;
   logic [CW-1:0] col;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] row;
   logic [RW-1:0] cur_row;
   logic sof_in;
   logic in_frame;
   logic accept;
   logic emit;
   logic [DATA_WIDTH-1:0] lb_rd [0:K-2];
   logic [0:K-1][DATA_WIDTH-1:0] column;
   logic [0:K-1][0:K-1][DATA_WIDTH-1:0] window;
   logic [0:K-1][0:K-1][DATA_WIDTH-1:0] window_next;

   // An accepted SOF restarts position at (0,0) whatever the state, which also masks stale lines.
   always_comb begin
      sof_in   = i_data_valid & i_start_of_frame;
      in_frame = (state == FILL) || (state == ACTIVE);
      accept   = sof_in | (i_data_valid & in_frame);
      cur_col  = sof_in ? '0 : col;
      cur_row  = sof_in ? '0 : row;
      emit     = accept && (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
   end

   for (genvar k = 0; k < K - 1; k++) begin : g_lb
      logic [DATA_WIDTH-1:0] wr_data;
      if (k == 0) begin : g_head
         assign wr_data = i_pixel;
      end else begin : g_tail
         assign wr_data = lb_rd[k-1];
      end
      line_buffer_ram #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (IMG_WIDTH)
      ) u_line (
         .i_clk   (i_clk),
         .wr_en   (accept),
         .addr    (cur_col),
         .wr_data (wr_data),
         .rd_data (lb_rd[k])
      );
   end

   always_comb begin
      column       = '0;
      window_next  = '0;
      for (int r = 0; r < K - 1; r++) begin
         column[r] = lb_rd[K-2-r];
      end
      column[K-1] = i_pixel;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            window_next[r][c] = window[r][c+1];
         end
         window_next[r][K-1] = column[r];
      end
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state                 <= IDLE;
         col                   <= '0;
         row                   <= '0;
         window                <= '0;
         o_image_kernel_buffer <= '0;
         o_data_valid          <= 1'b0;
         o_start_of_frame      <= 1'b0;
      end else begin
         o_data_valid     <= emit;
         o_start_of_frame <= emit && (cur_row == ROW_FIRST) && (cur_col == COL_FIRST);
         if (accept) begin
            window <= window_next;
            if (emit) begin
               o_image_kernel_buffer <= window_next;
            end
            if (cur_col == COL_LAST) begin
               col <= '0;
               row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
            if ((cur_col == COL_LAST) && (cur_row == ROW_LAST)) begin
               state <= DONE;
            end else if ((cur_col == COL_LAST) && (cur_row == ROW_FILL)) begin
               state <= ACTIVE;
            end else if (sof_in) begin
               state <= FILL;
            end
         end
      end
   end

`ifdef KERNEL_WINDOW_STATUS_EN
   // Flags aborted frames and valid pixels thrown away while waiting for SOF.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         o_frame_error <= 1'b0;
      end else begin
         o_frame_error <= (sof_in & in_frame) | (i_data_valid & ~i_start_of_frame & ~in_frame);
      end
   end
`endif

endmodule

// File: tb/tb_kernel_window_5x5.sv
// Self-checking bench for kernel_window_5x5 on an 8x6 image against an image-array reference.
// Frame-error checks are compiled in when KERNEL_WINDOW_STATUS_EN is defined.
module tb_kernel_window_5x5;

   localparam int DW = 8;
   localparam int K  = 5;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int BW = K * K * DW;

   typedef logic [0:K-1][0:K-1][DW-1:0] win_t;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] pixel = '0;
   logic          dv = 1'b0;
   logic          sof = 1'b0;
   win_t          win_out;
   logic          dv_out;
   logic          sof_out;
`ifdef KERNEL_WINDOW_STATUS_EN
   logic          err_out;
`endif

   int n_compared = 0;
   int n_mismatched = 0;

   logic [DW-1:0] img [0:H-1][0:W-1];
   bit   m_in_frame = 1'b0;
   int   m_row = 0;
   int   m_col = 0;
   win_t exp_held = '0;

   int   obs_windows = 0;
   int   obs_sofs = 0;
   int   obs_errors = 0;
   win_t first_win = '0;
   win_t last_win = '0;
   win_t frame_first_wins[$];

   kernel_window_5x5 #(
      .DATA_WIDTH  (DW),
      .KERNEL_SIZE (K),
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H)
   ) dut (
      .i_clk                 (clk),
      .i_aresetn             (aresetn),
      .i_pixel               (pixel),
      .i_data_valid          (dv),
      .i_start_of_frame      (sof),
      .o_image_kernel_buffer (win_out),
      .o_data_valid          (dv_out),
      .o_start_of_frame      (sof_out)
`ifdef KERNEL_WINDOW_STATUS_EN
      ,
      .o_frame_error         (err_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic resetCounters();
      obs_windows = 0;
      obs_sofs    = 0;
      obs_errors  = 0;
      frame_first_wins.delete();
   endtask

   // One clock of stimulus; the reference works from the frame image and pixel position only.
   task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] p);
      logic exp_dv;
      logic exp_sof;
      logic exp_err;
      exp_dv  = 1'b0;
      exp_sof = 1'b0;
      exp_err = 1'b0;
      dv    = v;
      sof   = s;
      pixel = p;
      @(posedge clk);
      #1;
      if (!aresetn) begin
         m_in_frame = 1'b0;
         exp_held   = '0;
      end else if (v) begin
         if (s) begin
            exp_err    = m_in_frame;
            m_in_frame = 1'b1;
            m_row      = 0;
            m_col      = 0;
         end else if (!m_in_frame) begin
            exp_err = 1'b1;
         end
         if (m_in_frame) begin
            img[m_row][m_col] = p;
            if (m_row >= K - 1 && m_col >= K - 1) begin
               exp_dv  = 1'b1;
               exp_sof = (m_row == K - 1) && (m_col == K - 1);
               for (int r = 0; r < K; r++) begin
                  for (int c = 0; c < K; c++) begin
                     exp_held[r][c] = img[m_row-K+1+r][m_col-K+1+c];
                  end
               end
            end
            m_col++;
            if (m_col == W) begin
               m_col = 0;
               m_row++;
               if (m_row == H) begin
                  m_row      = 0;
                  m_in_frame = 1'b0;
               end
            end
         end
      end
      if (dv_out === 1'b1) begin
         if (obs_windows == 0) first_win = win_out;
         last_win = win_out;
         obs_windows++;
      end
      if (sof_out === 1'b1) begin
         obs_sofs++;
         frame_first_wins.push_back(win_out);
      end
      checkOutput("o_data_valid", BW'(dv_out), BW'(exp_dv));
      checkOutput("o_start_of_frame", BW'(sof_out), BW'(exp_sof));
      checkOutput("o_image_kernel_buffer", win_out, exp_held);
`ifdef KERNEL_WINDOW_STATUS_EN
      if (err_out === 1'b1) obs_errors++;
      checkOutput("o_frame_error", BW'(err_out), BW'(exp_err));
`endif
   endtask

   task automatic sendFrame(input int n_pix, input int stall_pct);
      for (int i = 0; i < n_pix; i++) begin
         int stalls;
         stalls = 0;
         while (stalls < 20 && $urandom_range(99) < stall_pct) begin
            applyStimulus(1'b0, 1'($urandom_range(1)), 8'($urandom));
            stalls++;
         end
         applyStimulus(1'b1, i == 0, 8'(((i / W) << 4) | (i % W)));
      end
   endtask

   initial begin
      $display("[TB] reset state");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'($urandom));
      aresetn = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00);

      $display("[TB] scenario 1: continuous ramp frame");
      resetCounters();
      sendFrame(W * H, 0);
      checkOutput("s1_windows", BW'(obs_windows), BW'(8));
      checkOutput("s1_sofs", BW'(obs_sofs), BW'(1));
      checkOutput("s1_first_00", BW'(first_win[0][0]), BW'(8'h00));
      checkOutput("s1_first_44", BW'(first_win[4][4]), BW'(8'h44));
      checkOutput("s1_first_22", BW'(first_win[2][2]), BW'(8'h22));
      checkOutput("s1_last_44", BW'(last_win[4][4]), BW'(8'h57));

      $display("[TB] scenario 2: random stalls");
      resetCounters();
      sendFrame(W * H, 50);
      checkOutput("s2_windows", BW'(obs_windows), BW'(8));

      $display("[TB] scenario 3: abort at (3,2)");
      resetCounters();
      sendFrame(3 * W + 2, 0);
      sendFrame(W * H, 0);
      checkOutput("s3_windows", BW'(obs_windows), BW'(8));
`ifdef KERNEL_WINDOW_STATUS_EN
      checkOutput("s3_errors", BW'(obs_errors), BW'(1));
`endif

      $display("[TB] scenario 4: pixels without SOF");
      resetCounters();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
      checkOutput("s4_windows", BW'(obs_windows), BW'(0));
`ifdef KERNEL_WINDOW_STATUS_EN
      checkOutput("s4_errors", BW'(obs_errors), BW'(20));
`endif

      $display("[TB] scenario 5: reset mid-frame");
      sendFrame(4 * W + 6, 0);
      aresetn    = 1'b0;
      m_in_frame = 1'b0;
      exp_held   = '0;
      #1;
      checkOutput("s5_rst_valid", BW'(dv_out), BW'(0));
      checkOutput("s5_rst_window", win_out, '0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'($urandom));
      aresetn = 1'b1;
      resetCounters();
      sendFrame(W * H, 0);
      checkOutput("s5_windows", BW'(obs_windows), BW'(8));
      checkOutput("s5_sofs", BW'(obs_sofs), BW'(1));

      $display("[TB] scenario 6: back-to-back frames");
      resetCounters();
      sendFrame(W * H, 0);
      sendFrame(W * H, 0);
      checkOutput("s6_windows", BW'(obs_windows), BW'(16));
      checkOutput("s6_sofs", BW'(obs_sofs), BW'(2));
      if (frame_first_wins.size() == 2) begin
         checkOutput("s6_first_equal", frame_first_wins[1], frame_first_wins[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
